// File: rtl/ifetch_pkg.sv
// Shared definitions for the instruction fetch unit: FSM state encoding,
// the default sequential PC increment and the reset PC.
package ifetch_pkg;

    localparam int          PC_STEP_DEF = 4;
    localparam int unsigned RESET_PC    = 0;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        HOLD  = 2'd2,
        DROP  = 2'd3
    } ifetch_state_t;

endpackage

// File: rtl/ifetch_slot.sv
// Output slot toward decode: one presentation register plus a one-entry skid
// buffer that catches a fetched word when decode is stalled.
// Handshake: a word transfers on a cycle where o_valid=1 and i_ready=1;
// o_data/o_pc hold stable while o_valid=1 and i_ready=0.
module ifetch_slot
    import ifetch_pkg::*;
#(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  i_flush,
    input  logic                  i_wr_out,
    input  logic                  i_wr_skid,
    input  logic                  i_skid_to_out,
    input  logic [DATA_WIDTH-1:0] i_data,
    input  logic [DATA_WIDTH-1:0] i_pc,
    input  logic                  i_ready,
    output logic                  o_valid,
    output logic                  o_slot_free,
    output logic [DATA_WIDTH-1:0] o_data,
    output logic [DATA_WIDTH-1:0] o_pc
);

    logic                  r_valid;
    logic [DATA_WIDTH-1:0] r_data;
    logic [DATA_WIDTH-1:0] r_pc;
    logic                  r_skid_valid;
    logic [DATA_WIDTH-1:0] r_skid_data;
    logic [DATA_WIDTH-1:0] r_skid_pc;

    // Presentation register and skid buffer; a flush empties both.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_valid      <= 1'b0;
            r_data       <= '0;
            r_pc         <= '0;
            r_skid_valid <= 1'b0;
            r_skid_data  <= '0;
            r_skid_pc    <= '0;
        end else if (i_flush) begin
            r_valid      <= 1'b0;
            r_skid_valid <= 1'b0;
        end else begin
            if (i_wr_out) begin
                r_data  <= i_data;
                r_pc    <= i_pc;
                r_valid <= 1'b1;
            end else if (i_skid_to_out && r_skid_valid) begin
                r_data       <= r_skid_data;
                r_pc         <= r_skid_pc;
                r_valid      <= 1'b1;
                r_skid_valid <= 1'b0;
            end else if (i_ready) begin
                r_valid <= 1'b0;
            end
            if (i_wr_skid) begin
                r_skid_data  <= i_data;
                r_skid_pc    <= i_pc;
                r_skid_valid <= 1'b1;
            end
        end
    end

    assign o_valid     = r_valid;
    assign o_slot_free = !r_valid || i_ready;
    assign o_data      = r_data;
    assign o_pc        = r_pc;

endmodule

// File: rtl/ifetch_unit.sv
// Instruction fetch controller: drives the external PC register (pc_next /
// pc_en), fetches over imem req/ack and presents words to decode.
// Optional feature macro: IFETCH_MISALIGN_EN adds o_fetch_err and parks the
// unit on a misaligned PC or redirect target until the next redirect.
// imem handshake: o_imem_req is held with o_imem_addr stable until a cycle
// with i_imem_ack=1, which completes the request in that same cycle.
module ifetch_unit
    import ifetch_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int PC_STEP    = PC_STEP_DEF
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] i_pc_cur,
    output logic [DATA_WIDTH-1:0] o_pc_next,
    output logic                  o_pc_en,
    input  logic                  i_br_taken,
    input  logic [DATA_WIDTH-1:0] i_br_target,
    output logic                  o_imem_req,
    output logic [DATA_WIDTH-1:0] o_imem_addr,
    input  logic                  i_imem_ack,
    input  logic [DATA_WIDTH-1:0] i_imem_rdata,
    output logic                  o_inst_valid,
    input  logic                  i_inst_ready,
    output logic [DATA_WIDTH-1:0] o_inst_out,
    output logic [DATA_WIDTH-1:0] o_inst_pc,
`ifdef IFETCH_MISALIGN_EN
    output logic                  o_fetch_err,
`endif
    output ifetch_state_t         o_dbg_state
);

    ifetch_state_t         r_state;
    logic                  r_imem_req;
    logic [DATA_WIDTH-1:0] r_imem_addr;
    logic                  r_fetch_err;

    logic w_ack;
    logic w_fetch_done;
    logic w_slot_free;
    logic w_seq_adv;
    logic w_pc_bad;
    logic w_tgt_bad;

`ifdef IFETCH_MISALIGN_EN
    assign w_pc_bad    = |i_pc_cur[1:0];
    assign w_tgt_bad   = |i_br_target[1:0];
    assign o_fetch_err = r_fetch_err;
`else
    assign w_pc_bad    = 1'b0;
    assign w_tgt_bad   = 1'b0;
`endif

    // An ack only counts while a request is actually outstanding.
    assign w_ack        = r_imem_req && i_imem_ack;
    assign w_fetch_done = (r_state == FETCH) && w_ack;
    assign w_seq_adv    = (w_fetch_done || (r_state == HOLD)) && w_slot_free;

    // Redirect wins over the sequential step; arithmetic wraps naturally.
    assign o_pc_next = i_br_taken ? i_br_target : i_pc_cur + DATA_WIDTH'(PC_STEP);
    assign o_pc_en   = !rst && (i_br_taken || w_seq_adv);

    // Fetch FSM: IDLE -> FETCH (issue, then wait ack) -> IDLE or HOLD; DROP
    // absorbs the ack of a request made stale by a redirect.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= IDLE;
            r_imem_req  <= 1'b0;
            r_imem_addr <= DATA_WIDTH'(RESET_PC);
            r_fetch_err <= 1'b0;
        end else if (i_br_taken) begin
            r_fetch_err <= w_tgt_bad;
            if (r_imem_req && !i_imem_ack) begin
                r_state <= DROP;
            end else begin
                r_state    <= IDLE;
                r_imem_req <= 1'b0;
            end
        end else begin
            case (r_state)
                IDLE: begin
                    if (!r_fetch_err) r_state <= FETCH;
                end
                FETCH: begin
                    if (!r_imem_req) begin
                        if (w_pc_bad) begin
                            r_fetch_err <= 1'b1;
                            r_state     <= IDLE;
                        end else begin
                            r_imem_req  <= 1'b1;
                            r_imem_addr <= i_pc_cur;
                        end
                    end else if (i_imem_ack) begin
                        r_imem_req <= 1'b0;
                        r_state    <= w_slot_free ? IDLE : HOLD;
                    end
                end
                HOLD: begin
                    if (w_slot_free) r_state <= IDLE;
                end
                DROP: begin
                    if (i_imem_ack) begin
                        r_imem_req <= 1'b0;
                        r_state    <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    ifetch_slot #(.DATA_WIDTH(DATA_WIDTH)) u_slot (
        .clk          (clk),
        .rst          (rst),
        .i_flush      (i_br_taken),
        .i_wr_out     (w_fetch_done && w_slot_free),
        .i_wr_skid    (w_fetch_done && !w_slot_free),
        .i_skid_to_out((r_state == HOLD) && w_slot_free),
        .i_data       (i_imem_rdata),
        .i_pc         (r_imem_addr),
        .i_ready      (i_inst_ready),
        .o_valid      (o_inst_valid),
        .o_slot_free  (w_slot_free),
        .o_data       (o_inst_out),
        .o_pc         (o_inst_pc)
    );

    assign o_imem_req  = r_imem_req;
    assign o_imem_addr = r_imem_addr;
    assign o_dbg_state = r_state;

endmodule

// File: tb/tb_ifetch_unit.sv
// Bench for ifetch_unit: external PC register, randomized-latency memory,
// and an in-order instruction-stream scoreboard.
module tb_ifetch_unit;
    import ifetch_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] pc_cur;
    logic [31:0] o_pc_next;
    logic        o_pc_en;
    logic        br_taken;
    logic [31:0] br_target;
    logic        o_imem_req;
    logic [31:0] o_imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic        o_inst_valid;
    logic        inst_ready;
    logic [31:0] o_inst_out;
    logic [31:0] o_inst_pc;
    ifetch_state_t o_dbg_state;
`ifdef IFETCH_MISALIGN_EN
    logic        fetch_err;
`endif

    ifetch_unit #(.DATA_WIDTH(32), .PC_STEP(4)) dut (
        .clk         (clk),
        .rst         (rst),
        .i_pc_cur    (pc_cur),
        .o_pc_next   (o_pc_next),
        .o_pc_en     (o_pc_en),
        .i_br_taken  (br_taken),
        .i_br_target (br_target),
        .o_imem_req  (o_imem_req),
        .o_imem_addr (o_imem_addr),
        .i_imem_ack  (imem_ack),
        .i_imem_rdata(imem_rdata),
        .o_inst_valid(o_inst_valid),
        .i_inst_ready(inst_ready),
        .o_inst_out  (o_inst_out),
        .o_inst_pc   (o_inst_pc),
`ifdef IFETCH_MISALIGN_EN
        .o_fetch_err (fetch_err),
`endif
        .o_dbg_state (o_dbg_state)
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    // ---------------- bookkeeping ----------------
    int n_checks = 0;
    int n_errors = 0;
    int delivered = 0;
    int cyc = 0;
    int idle_cnt = 0;
    int last_en_cyc = 0;
    bit gap_mode = 1'b0;
    int wait_lo = 0;
    int wait_hi = 0;

    logic [63:0] exp_q[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Memory contents: a bijective scramble of the address.
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {a[15:0], ~a[31:16]} ^ 32'h1357_9BDF;
    endfunction

    // ---------------- external PC register ----------------
    initial begin
        logic        s_rst;
        logic        s_en;
        logic [31:0] s_next;
        pc_cur = 32'h0;
        forever begin
            @(negedge clk);
            s_rst  = rst;
            s_en   = o_pc_en;
            s_next = o_pc_next;
            @(posedge clk);
            #1;
            if (s_rst) pc_cur = 32'h0;
            else if (s_en) pc_cur = s_next;
        end
    end

    // ---------------- instruction memory ----------------
    initial begin
        bit busy;
        int mcnt;
        int mwait;
        busy = 1'b0;
        mcnt = 0;
        mwait = 0;
        imem_ack = 1'b0;
        imem_rdata = 32'h0;
        forever begin
            @(posedge clk);
            #1;
            imem_ack = 1'b0;
            imem_rdata = $urandom;
            if (o_imem_req) begin
                if (!busy) begin
                    busy = 1'b1;
                    mcnt = 0;
                    mwait = int'($urandom_range(wait_hi, wait_lo));
                end
                if (mcnt >= mwait) begin
                    imem_ack = 1'b1;
                    imem_rdata = mem_word(o_imem_addr);
                    busy = 1'b0;
                end else begin
                    mcnt++;
                end
            end else begin
                busy = 1'b0;
            end
        end
    end

    // ---------------- monitor / scoreboard ----------------
    logic        rst_d = 1'b1;
    logic        br_d = 1'b0;
    logic        en_d = 1'b0;
    logic        req_d = 1'b0;
    logic        ack_d = 1'b0;
    logic [31:0] addr_d = 32'h0;

    always @(negedge clk) begin
        logic [63:0] head;
        logic [31:0] nxt;
        cyc++;
        if (rst) begin
            check("pc_en_in_reset", 32'(o_pc_en), 32'd0);
            exp_q.delete();
            exp_q.push_back({32'h0, mem_word(32'h0)});
            idle_cnt = 0;
        end else begin
            if (rst_d) begin
                check("rst_imem_req", 32'(o_imem_req), 32'd0);
                check("rst_imem_addr", o_imem_addr, 32'd0);
                check("rst_inst_valid", 32'(o_inst_valid), 32'd0);
                check("rst_inst_out", o_inst_out, 32'd0);
                check("rst_inst_pc", o_inst_pc, 32'd0);
                check("rst_state", 32'(o_dbg_state), 32'(IDLE));
`ifdef IFETCH_MISALIGN_EN
                check("rst_fetch_err", 32'(fetch_err), 32'd0);
`endif
            end
            if (br_d) check("valid_after_redirect", 32'(o_inst_valid), 32'd0);
            check("pc_next", o_pc_next, br_taken ? br_target : pc_cur + 32'd4);
            if (br_taken) check("pc_en_on_redirect", 32'(o_pc_en), 32'd1);
            check("pc_en_spacing", 32'(o_pc_en && en_d && !br_taken && !br_d), 32'd0);
            if (gap_mode && o_pc_en && !br_taken) begin
                if (last_en_cyc != 0) check("pc_en_period", 32'(cyc - last_en_cyc), 32'd3);
                last_en_cyc = cyc;
            end
            if (req_d && !ack_d && !rst_d) begin
                check("imem_req_held", 32'(o_imem_req), 32'd1);
                check("imem_addr_stable", o_imem_addr, addr_d);
            end
            if (o_inst_valid) begin
                if (exp_q.size() == 0) begin
                    check("exp_q_size", 32'(exp_q.size()), 32'd1);
                end else begin
                    head = exp_q[0];
                    check("inst_pc", o_inst_pc, head[63:32]);
                    check("inst_out", o_inst_out, head[31:0]);
                    if (inst_ready) begin
                        void'(exp_q.pop_front());
                        nxt = head[63:32] + 32'd4;
                        exp_q.push_back({nxt, mem_word(nxt)});
                        delivered++;
                        idle_cnt = 0;
                    end
                end
            end
            if (br_taken) begin
                exp_q.delete();
                exp_q.push_back({br_target, mem_word(br_target)});
                idle_cnt = 0;
            end
            idle_cnt++;
            if (idle_cnt > 150) begin
                check("progress_watchdog", 32'(idle_cnt), 32'd150);
                idle_cnt = 0;
            end
        end
        rst_d  = rst;
        br_d   = br_taken;
        en_d   = o_pc_en;
        req_d  = o_imem_req;
        ack_d  = imem_ack;
        addr_d = o_imem_addr;
    end

    // ---------------- driver tasks ----------------
    task automatic redirect(input logic [31:0] t);
        @(posedge clk);
        #2;
        br_taken = 1'b1;
        br_target = t;
        @(posedge clk);
        #2;
        br_taken = 1'b0;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int  n;
        int  k;
        bit  hit;
        bit  saw_hold;
        rst = 1'b1;
        br_taken = 1'b0;
        br_target = 32'h0;
        inst_ready = 1'b1;
        repeat (3) @(posedge clk);
        #2 rst = 1'b0;

        // Zero-wait sequential stream from PC 0.
        last_en_cyc = 0;
        gap_mode = 1'b1;
        repeat (30) @(posedge clk);
        gap_mode = 1'b0;

        // Slow memory at 0x100.
        wait_lo = 5;
        wait_hi = 5;
        redirect(32'h100);
        n = 0;
        k = 0;
        while (!o_inst_valid && k < 60) begin
            @(negedge clk);
            if (o_imem_req && o_imem_addr == 32'h100) n++;
            k++;
        end
        check("delay_req_cycles", 32'(n), 32'd6);

        // Redirect while a request to 0x10 is outstanding.
        wait_lo = 6;
        wait_hi = 6;
        redirect(32'h10);
        k = 0;
        while (!(o_imem_req && o_imem_addr == 32'h10) && k < 50) begin
            @(negedge clk);
            k++;
        end
        check("drop_req_seen", 32'(o_imem_req && o_imem_addr == 32'h10), 32'd1);
        redirect(32'h200);
        wait_lo = 0;
        wait_hi = 0;
        repeat (25) @(posedge clk);

        // Decode stall long enough to fill the skid buffer.
        saw_hold = 1'b0;
        @(posedge clk);
        #2 inst_ready = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (o_dbg_state == HOLD) saw_hold = 1'b1;
        end
        @(posedge clk);
        #2 inst_ready = 1'b1;
        check("hold_entered", 32'(saw_hold), 32'd1);
        repeat (12) @(posedge clk);

        // Redirect on the same cycle as an ack.
        wait_lo = 2;
        wait_hi = 2;
        hit = 1'b0;
        for (int i = 0; i < 40 && !hit; i++) begin
            @(posedge clk);
            #2;
            if (imem_ack) begin
                br_taken = 1'b1;
                br_target = 32'h400;
                hit = 1'b1;
                @(posedge clk);
                #2 br_taken = 1'b0;
            end
        end
        check("coincident_hit", 32'(hit), 32'd1);
        repeat (15) @(posedge clk);

        // Address wrap.
        wait_lo = 0;
        wait_hi = 0;
        redirect(32'hFFFF_FFF8);
        repeat (15) @(posedge clk);

        // Reset in the middle of a handshake, with a redirect ignored by reset.
        wait_lo = 4;
        wait_hi = 4;
        k = 0;
        while (!o_imem_req && k < 30) begin
            @(negedge clk);
            k++;
        end
        @(posedge clk);
        #2;
        rst = 1'b1;
        br_taken = 1'b1;
        br_target = 32'h500;
        @(posedge clk);
        #2 br_taken = 1'b0;
        @(posedge clk);
        #2 rst = 1'b0;
        repeat (25) @(posedge clk);

        // Randomized traffic.
        wait_lo = 0;
        wait_hi = 3;
        for (int i = 0; i < 600; i++) begin
            @(posedge clk);
            #2;
            inst_ready = ($urandom_range(9, 0) < 7);
            if (!br_taken && $urandom_range(14, 0) == 0) begin
                br_taken = 1'b1;
                if ($urandom_range(3, 0) == 0) br_target = 32'hFFFF_FFF0 | ($urandom & 32'hC);
                else br_target = $urandom & 32'h0000_FFFC;
            end else begin
                br_taken = 1'b0;
            end
        end
        @(posedge clk);
        #2;
        br_taken = 1'b0;
        inst_ready = 1'b1;
        wait_lo = 0;
        wait_hi = 0;
        repeat (20) @(posedge clk);

`ifdef IFETCH_MISALIGN_EN
        // Misaligned redirect parks the unit until an aligned redirect.
        redirect(32'h202);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("fetch_err_set", 32'(fetch_err), 32'd1);
            check("req_parked", 32'(o_imem_req), 32'd0);
            check("pc_en_parked", 32'(o_pc_en), 32'd0);
        end
        redirect(32'h300);
        @(negedge clk);
        check("fetch_err_clear", 32'(fetch_err), 32'd0);
        repeat (15) @(posedge clk);
`endif

        check("delivered_min", 32'(delivered >= 50), 32'd1);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/ifetch_unit.md
Name: ifetch_unit

Overview:
Instruction fetch controller; the consumer and driver side of the PC register.
- Reads the current PC (pc_cur) and computes the next PC (pc_next, pc_en) back into the PC register.
- Fetches from instruction memory over a req/ack handshake and presents instructions to decode over a valid/ready handshake.
- Handles branch redirect and discards fetches made stale by a redirect.

Parameters:
DATA_WIDTH, 32, width of PC, addresses and instruction words
PC_STEP, 4, byte increment for sequential fetch

Ports:
clk  input  1  rising-edge clock
rst  input  1  synchronous, active-high reset
pc_cur  input  DATA_WIDTH  current PC from PC register output
pc_next  output  DATA_WIDTH  next PC to PC register data input (combinational)
pc_en  output  1  PC register load enable (combinational)
br_taken  input  1  redirect request, single-cycle pulse
br_target  input  DATA_WIDTH  redirect address
imem_req  output  1  memory request, held until ack
imem_addr  output  DATA_WIDTH  request address, stable while imem_req=1
imem_ack  input  1  read data valid this cycle
imem_rdata  input  DATA_WIDTH  instruction word
inst_valid  output  1  output slot holds an instruction
inst_ready  input  1  decode accepts the slot this cycle
inst_out  output  DATA_WIDTH  instruction word
inst_pc  output  DATA_WIDTH  address of inst_out

Behaviour:
- Reset: state=IDLE; imem_req=0, imem_addr=0, inst_valid=0, inst_out=0, inst_pc=0, skid buffer empty. pc_en=0 while rst=1. Reset mid-handshake abandons the request; a late ack is ignored because the block is in IDLE.
- pc_next = br_taken ? br_target : pc_cur + PC_STEP, modulo 2^DATA_WIDTH. 0xFFFFFFFC+4 wraps to 0.
- Slot free = !inst_valid || inst_ready.

States:
- IDLE: next cycle goes to FETCH.
- FETCH: registers imem_addr<=pc_cur and imem_req<=1 on entry, then waits for imem_ack.
  - Ack with slot free: inst_out<=rdata, inst_pc<=imem_addr, inst_valid<=1, pc_en=1, imem_req<=0; go to IDLE (new PC visible next cycle).
  - Ack with slot not free: data into skid buffer; go to HOLD.
- HOLD: imem_req=0. When slot free: load from skid, pc_en=1, go to IDLE.
- DROP: imem_req stays 1 until ack; discard ack data; go to IDLE.

Timing:
- Throughput: one instruction per 3 cycles with zero-wait memory.
- Fetch latency: 1 cycle plus memory wait.

Redirect (br_taken=1 in any non-reset cycle):
- pc_en=1, pc_next=br_target, inst_valid<=0, skid cleared.
- If FETCH with req outstanding and no ack this cycle: go to DROP.
- If ack arrives the same cycle: discard data, go to IDLE.
- Otherwise: go to IDLE.
- Redirect has priority over sequential pc_en.

Handshake rules:
- inst_out and inst_pc hold stable while inst_valid=1 and inst_ready=0.
- pc_en is never asserted on two consecutive cycles except for a redirect.

Optional Feature:
IFETCH_MISALIGN_EN
- Defined: adds output fetch_err (1 bit, reset 0), set when pc_cur[1:0]!=0 at FETCH entry or br_target[1:0]!=0 on redirect. The request is not issued; the block parks in IDLE with pc_en=0 until the next redirect clears fetch_err.
- Undefined: no port; address low bits are passed through unchecked.

Decomposition:
- Package ifetch_pkg: state enum (IDLE, FETCH, HOLD, DROP), PC_STEP default, RESET_PC constant 0.
- One natural sub-module, ifetch_slot: the output register plus skid buffer with the valid/ready logic.
- Keeping the FSM and PC arithmetic in the top keeps each file small.

Test Plan:
- Zero-wait memory, pc_cur=0, inst_ready=1 always -> inst_pc sequence 0,4,8 with one pc_en pulse per 3 cycles; inst_out matches memory.
- Memory ack delayed 5 cycles at 0x100 -> imem_req stays 1 and imem_addr stays 0x100 for 5 cycles, then inst_valid=1 with inst_pc=0x100.
- inst_ready=0 for 4 cycles with a second fetch acked meanwhile -> inst_out stays at the first word; the second enters HOLD and emits after ready rises; no word lost or duplicated.
- br_taken with target 0x200 while req outstanding to 0x10 -> DROP; 0x10 data discarded; next inst_pc=0x200.
- br_taken coincident with imem_ack -> acked data discarded, pc_next=br_target, inst_valid=0 next cycle.
- pc_cur=0xFFFFFFFC fetched -> pc_next=0x00000000; with IFETCH_MISALIGN_EN, br_target=0x202 -> fetch_err=1, imem_req stays 0.
